// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: frame-wide sample buffer with continuous FIFO streaming and pre/post-trigger capture
module adc_capture_buffer #(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1,
   localparam int FW = NUM_CHANNELS * DATA_WIDTH,
   localparam int SW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_valid,
   input  logic [FW-1:0] sample_data,
   input  logic          mode,
   input  logic          arm,
   input  logic          abort,
   input  logic          trigger,
   input  logic [AW-1:0] pretrig_len,
   input  logic [CW-1:0] posttrig_len,
   input  logic          rd_en,
   input  logic [SW-1:0] rd_ch,
   output logic          rd_valid,
   output logic [FW-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] rd_ch_data,
   output logic          not_empty,
   output logic          full,
   output logic [CW-1:0] count,
   output logic [2:0]    state_o,
   output logic          overflow,
   output logic [31:0]   trig_stamp
);
   typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pre_q, pre_d;
   logic [CW-1:0] count_q, count_d, post_q, post_d, post_cnt_q, post_cnt_d;
   logic overflow_q, overflow_d, rd_valid_q, rd_valid_d;
   logic [31:0] smp_cnt_q, smp_cnt_d, trig_stamp_q, trig_stamp_d;
   logic [FW-1:0] rd_data_q, rd_data_d;
   logic [FW-1:0] mem [DEPTH];
   logic wr_en, pop, post_wr, at_pre;
   assign at_pre = count_q == CW'(pre_q);
   assign full = count_q == CW'(DEPTH);
   assign not_empty = count_q != '0 && (state_q == RUN || state_q == DONE || state_q == IDLE);
   assign count = count_q;
   assign state_o = state_q;
   assign overflow = overflow_q;
   assign trig_stamp = trig_stamp_q;
   assign rd_valid = rd_valid_q;
   assign rd_data = rd_data_q;
   assign rd_ch_data = rd_data_q[32'(rd_ch) * DATA_WIDTH +: DATA_WIDTH];
   always_comb begin
      state_d = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pre_d = pre_q;
      count_d = count_q;
      post_d = post_q;
      post_cnt_d = post_cnt_q;
      overflow_d = overflow_q;
      smp_cnt_d = smp_cnt_q;
      trig_stamp_d = trig_stamp_q;
      rd_data_d = rd_data_q;
      rd_valid_d = 1'b0;
      wr_en = 1'b0;
      pop = 1'b0;
      post_wr = 1'b0;
      case (state_q)
         IDLE: if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d = '0;
            overflow_d = 1'b0;
            trig_stamp_d = '0;
            smp_cnt_d = '0;
            post_cnt_d = '0;
            pre_d = pretrig_len;
            post_d = posttrig_len;
            state_d = mode ? ARMED : RUN;
         end
         RUN: begin
            pop = rd_en && count_q != '0;
            wr_en = sample_valid && (!full || pop);
            overflow_d = overflow_q || (sample_valid && !wr_en);
            count_d = count_q + CW'(wr_en) - CW'(pop);
         end
         ARMED: begin
            wr_en = sample_valid;
            smp_cnt_d = (sample_valid && smp_cnt_q != '1) ? smp_cnt_q + 32'd1 : smp_cnt_q;
            if (trigger && at_pre) begin
               trig_stamp_d = smp_cnt_q;
               state_d = POST;
               post_wr = sample_valid;
            end else if (sample_valid) begin
               // once the pre-trigger window is full, drop the oldest frame to keep it sliding
               rd_ptr_d = at_pre ? rd_ptr_q + AW'(1) : rd_ptr_q;
               count_d = at_pre ? count_q : count_q + CW'(1);
            end
         end
         POST: begin
            wr_en = sample_valid;
            post_wr = sample_valid;
         end
         DONE: begin
            pop = rd_en && count_q != '0;
            count_d = count_q - CW'(pop);
            state_d = (pop && count_q == CW'(1)) ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
      if (post_wr) begin
         count_d = count_q + CW'(1);
         post_cnt_d = post_cnt_q + CW'(1);
         state_d = post_cnt_d == post_q ? DONE : POST;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         rd_data_d = mem[rd_ptr_q];
         rd_valid_d = 1'b1;
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (abort) begin
         state_d = IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d = '0;
         wr_en = 1'b0;
         pop = 1'b0;
         rd_valid_d = 1'b0;
         rd_data_d = rd_data_q;
      end
   end
   always_ff @(posedge clk) if (wr_en) mem[wr_ptr_q] <= sample_data;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pre_q <= '0;
         count_q <= '0;
         post_q <= '0;
         post_cnt_q <= '0;
         overflow_q <= 1'b0;
         smp_cnt_q <= '0;
         trig_stamp_q <= '0;
         rd_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pre_q <= pre_d;
         count_q <= count_d;
         post_q <= post_d;
         post_cnt_q <= post_cnt_d;
         overflow_q <= overflow_d;
         smp_cnt_q <= smp_cnt_d;
         trig_stamp_q <= trig_stamp_d;
         rd_data_q <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: vector-table and directed-sequence bench for adc_capture_buffer at DEPTH=16
module tb_adc_capture_buffer;
   logic clk = 1'b0, rst = 1'b1;
   logic sample_valid, mode, arm, abort, trigger, rd_en;
   logic [47:0] sample_data;
   logic [3:0] pretrig_len;
   logic [4:0] posttrig_len;
   logic [1:0] rd_ch;
   logic rd_valid, not_empty, full, overflow;
   logic [47:0] rd_data;
   logic [11:0] rd_ch_data;
   logic [4:0] count;
   logic [2:0] state_o;
   logic [31:0] trig_stamp;
   int n_vec = 0, n_err = 0;

   adc_capture_buffer #(.NUM_CHANNELS(4), .DATA_WIDTH(12), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
      .mode(mode), .arm(arm), .abort(abort), .trigger(trigger),
      .pretrig_len(pretrig_len), .posttrig_len(posttrig_len), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ch_data(rd_ch_data), .not_empty(not_empty),
      .full(full), .count(count), .state_o(state_o), .overflow(overflow), .trig_stamp(trig_stamp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic sv, arm, rd_en, abort;
      logic [47:0] d;
      logic [2:0] e_state;
      logic [4:0] e_count;
      logic e_valid, e_full, e_ne, e_ovf;
      logic [47:0] e_data;
   } vec_t;
   vec_t vt[$];

   function automatic logic [47:0] frame(input int k);
      logic [11:0] b;
      b = 12'(k);
      return {b | 12'h300, b | 12'h200, b | 12'h100, b};
   endfunction

   function automatic vec_t nv(input logic [2:0] st, input int cnt, input logic ovf);
      vec_t v;
      v.sv = 1'b0; v.arm = 1'b0; v.rd_en = 1'b0; v.abort = 1'b0; v.d = '0;
      v.e_state = st; v.e_count = 5'(cnt); v.e_valid = 1'b0;
      v.e_full = cnt == 16; v.e_ne = cnt != 0 && st != 3'd2 && st != 3'd3; v.e_ovf = ovf;
      v.e_data = '0;
      return v;
   endfunction

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      sample_valid = 0; arm = 0; abort = 0; trigger = 0; rd_en = 0;
   endtask

   task automatic put(input logic [47:0] d);
      sample_valid = 1; sample_data = d;
      tick();
      sample_valid = 0;
   endtask

   initial begin
      vec_t v;
      clr();
      mode = 0; sample_data = '0; pretrig_len = '0; posttrig_len = 5'd1; rd_ch = '0;
      v = nv(3'd1, 0, 0); v.arm = 1; vt.push_back(v);
      for (int j = 1; j <= 20; j++) begin
         v = nv(3'd1, j > 16 ? 16 : j, j >= 17); v.sv = 1; v.d = frame(j - 1); vt.push_back(v);
      end
      for (int p = 1; p <= 16; p++) begin
         v = nv(3'd1, 16 - p, 1); v.rd_en = 1; v.e_valid = 1; v.e_data = frame(p - 1); vt.push_back(v);
      end
      vt.push_back(nv(3'd1, 0, 1));
      v = nv(3'd0, 0, 1); v.abort = 1; vt.push_back(v);
      v = nv(3'd1, 0, 0); v.arm = 1; vt.push_back(v);
      for (int j = 1; j <= 16; j++) begin
         v = nv(3'd1, j, 0); v.sv = 1; v.d = frame(29 + j); vt.push_back(v);
      end
      for (int k = 0; k < 5; k++) begin
         v = nv(3'd1, 16, 0); v.sv = 1; v.rd_en = 1; v.d = frame(100 + k);
         v.e_valid = 1; v.e_data = frame(30 + k); vt.push_back(v);
      end
      for (int p = 0; p < 16; p++) begin
         v = nv(3'd1, 15 - p, 0); v.rd_en = 1; v.e_valid = 1;
         v.e_data = p < 11 ? frame(35 + p) : frame(89 + p); vt.push_back(v);
      end

      repeat (2) @(posedge clk);
      #3 rst = 0;
      chk("reset state", state_o, 0);
      chk("reset count", count, 0);
      chk("reset flags", {full, not_empty, overflow, rd_valid}, 0);
      chk("reset rd_data", rd_data, 0);
      chk("reset trig_stamp", trig_stamp, 0);

      foreach (vt[i]) begin
         sample_valid = vt[i].sv; sample_data = vt[i].d; arm = vt[i].arm;
         rd_en = vt[i].rd_en; abort = vt[i].abort;
         tick();
         clr();
         chk($sformatf("v%0d state", i), state_o, vt[i].e_state);
         chk($sformatf("v%0d count", i), count, vt[i].e_count);
         chk($sformatf("v%0d rd_valid", i), rd_valid, vt[i].e_valid);
         chk($sformatf("v%0d full", i), full, vt[i].e_full);
         chk($sformatf("v%0d not_empty", i), not_empty, vt[i].e_ne);
         chk($sformatf("v%0d overflow", i), overflow, vt[i].e_ovf);
         if (vt[i].e_valid) chk($sformatf("v%0d rd_data", i), rd_data, vt[i].e_data);
      end

      abort = 1; tick(); clr();
      arm = 1; mode = 1; pretrig_len = 4'd4; posttrig_len = 5'd3; tick(); clr();
      chk("trig armed", state_o, 2);
      for (int k = 0; k < 10; k++) put(frame(k));
      chk("trig pre count", count, 4);
      chk("trig pre state", state_o, 2);
      chk("trig pre not_empty", not_empty, 0);
      trigger = 1; sample_valid = 1; sample_data = frame(10); tick(); clr();
      chk("trig stamp", trig_stamp, 10);
      chk("trig post state", state_o, 3);
      chk("trig post count", count, 5);
      put(frame(11));
      chk("trig post2 state", state_o, 3);
      put(frame(12));
      chk("trig done state", state_o, 4);
      chk("trig done count", count, 7);
      for (int p = 0; p < 7; p++) begin
         rd_en = 1; tick(); clr();
         chk($sformatf("trig pop%0d data", p), rd_data, frame(6 + p));
         chk($sformatf("trig pop%0d valid", p), rd_valid, 1);
         chk($sformatf("trig pop%0d state", p), state_o, p == 6 ? 0 : 4);
      end
      chk("trig end count", count, 0);

      arm = 1; mode = 1; pretrig_len = 4'd8; posttrig_len = 5'd2; tick(); clr();
      for (int k = 0; k < 3; k++) put(frame(20 + k));
      trigger = 1; tick(); clr();
      chk("early trig state", state_o, 2);
      chk("early trig stamp", trig_stamp, 0);
      for (int k = 3; k < 8; k++) put(frame(20 + k));
      chk("early count", count, 8);
      trigger = 1; tick(); clr();
      chk("late trig state", state_o, 3);
      chk("late trig stamp", trig_stamp, 8);
      abort = 1; sample_valid = 1; rd_en = 1; sample_data = frame(60); tick(); clr();
      chk("abort state", state_o, 0);
      chk("abort count", count, 0);
      chk("abort rd_valid", rd_valid, 0);
      arm = 1; mode = 0; tick(); clr();
      chk("restart state", state_o, 1);
      put(frame(50));
      chk("restart count", count, 1);
      rd_en = 1; tick(); clr();
      chk("restart data", rd_data, frame(50));
      chk("restart valid", rd_valid, 1);
      tick();
      chk("rd_valid pulse", rd_valid, 0);

      put({12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA});
      rd_en = 1; tick(); clr();
      for (int c = 0; c < 4; c++) begin
         rd_ch = 2'(c);
         #1 chk($sformatf("rd_ch %0d", c), rd_ch_data, 12'hAAA + 12'(c) * 12'h111);
      end

      abort = 1; tick(); clr();
      arm = 1; mode = 1; pretrig_len = 4'd2; posttrig_len = 5'd4; tick(); clr();
      for (int k = 0; k < 3; k++) put(frame(70 + k));
      trigger = 1; tick(); clr();
      chk("pre-rst state", state_o, 3);
      chk("pre-rst stamp", trig_stamp, 3);
      #2 rst = 1;
      #1;
      chk("async rst state", state_o, 0);
      chk("async rst count", count, 0);
      chk("async rst flags", {full, not_empty, overflow, rd_valid}, 0);
      chk("async rst rd_data", rd_data, 0);
      chk("async rst rd_ch_data", rd_ch_data, 0);
      chk("async rst stamp", trig_stamp, 0);
      #2 rst = 0;
      tick();
      chk("post-rst state", state_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
